// File: rtl/cle_pkg.sv
// Shared definitions for the connected-component labeler.
// Holds the labeler FSM state type, the address-width derivations used
// to size the ROM/SRAM ports, and a small byte bit-reversal helper.
package cle_pkg;

    // Top-level sequencing of a labeling run
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        BFS,
        DONE
    } cle_state_t;

    // Width of a pixel index / SRAM address for a w x h image
    function automatic int pix_addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

    // Width of a ROM byte address (8 pixels per byte)
    function automatic int rom_addr_w(input int w, input int h);
        return $clog2((w * h) / 8);
    endfunction

    // ROM bytes carry the leftmost pixel in bit 7, while the internal
    // bit image keeps the lowest pixel index in the lowest bit.
    function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/cle_queue.sv
// Synchronous FIFO used as the BFS work queue of the labeler.
// Ports:
//   clk, reset (async active-low)  - clock and reset
//   clr                            - synchronous pointer/count clear
//   push, din                      - enqueue din when push is high
//   pop                            - dequeue the head entry
//   dout                           - current head entry (valid when !empty)
//   empty                          - no entries stored
// Push and pop in the same cycle are both honoured. DEPTH must be a
// power of two so the pointers wrap naturally.
module cle_queue #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty queue is dropped; a push is refused only when
    // full and not simultaneously popping.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cle_param.sv
// Connected-component labeler for a binary image held in a byte ROM.
// A run loads the image into an internal bit map, scans it in raster
// order and floods each new component breadth-first, writing one label
// per pixel into an external SRAM (0 = background, 1.. = components).
// Ports:
//   clk, reset (async active-low)
//   start      - pulse to begin a run (accepted in IDLE or DONE)
//   rom_a/rom_q- ROM byte address / data (data one cycle after address)
//   sram_a/d   - SRAM write address (row*IMG_W+col) and label
//   sram_wen   - active-low SRAM write strobe
//   label_cnt  - labels assigned so far in this run (saturating)
//   ovf        - sticky label overflow flag
//   finish     - high while the run is complete (DONE)
module cle_param
    import cle_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int LBL_W = 8,
    parameter int CONN8 = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic [rom_addr_w(IMG_W, IMG_H)-1:0]    rom_a,
    input  logic [7:0]                             rom_q,
    output logic [pix_addr_w(IMG_W, IMG_H)-1:0]    sram_a,
    output logic [LBL_W-1:0]                       sram_d,
    output logic                                   sram_wen,
    output logic [LBL_W-1:0]                       label_cnt,
    output logic                                   ovf,
    output logic                                   finish
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NBYTE = NPIX / 8;
    localparam int PA_W  = pix_addr_w(IMG_W, IMG_H);
    localparam int RA_W  = rom_addr_w(IMG_W, IMG_H);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = PA_W - XW;
    localparam int NNB   = (CONN8 != 0) ? 8 : 4;

    localparam logic [LBL_W-1:0] LBL_MAX   = '1;
    localparam logic [PA_W-1:0]  LAST_PIX  = PA_W'(NPIX - 1);
    localparam logic [RA_W:0]    LOAD_END  = (RA_W+1)'(NBYTE);
    localparam logic [RA_W:0]    LAST_BYTE = (RA_W+1)'(NBYTE - 1);

    cle_state_t       state;
    cle_state_t       state_nxt;

    logic [RA_W:0]    ld_cnt;
    logic [RA_W-1:0]  ld_byte;
    logic [PA_W-1:0]  scan_idx;
    logic [PA_W-1:0]  cur_px;
    logic             pop_phase;
    logic [2:0]       nb_idx;

    // img: still-unclaimed foreground; vis: already queued this run
    logic [NPIX-1:0]  img;
    logic [NPIX-1:0]  vis;

    logic             q_clr;
    logic             q_push;
    logic             q_pop;
    logic [PA_W-1:0]  q_din;
    logic [PA_W-1:0]  q_dout;
    logic             q_empty;

    logic             wr_en;
    logic [PA_W-1:0]  wr_addr;
    logic [LBL_W-1:0] wr_data;
    logic             new_comp;

    logic [2:0]       nb_sel;
    logic             go_u, go_d, go_l, go_r;
    logic             nb_ok;
    logic             nb_hit;
    logic [XW-1:0]    cur_x, nb_x;
    logic [YW-1:0]    cur_y, nb_y;
    logic [PA_W-1:0]  nb_px;

    assign finish  = (state == DONE);
    assign ld_byte = RA_W'(ld_cnt - (RA_W+1)'(1));
    assign cur_x   = cur_px[XW-1:0];
    assign cur_y   = cur_px[PA_W-1:XW];

    cle_queue #(
        .DEPTH (NPIX),
        .WIDTH (PA_W)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .clr   (q_clr),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_dout),
        .empty (q_empty)
    );

    // Neighbour generator: nb_idx walks the neighbourhood of cur_px one
    // position per cycle. In 4-connected mode only the N/W/E/S slots of
    // the 8-neighbour table are visited. Offsets that would leave the
    // image (including wrapping across a row edge) are rejected.
    always_comb begin
        nb_sel = nb_idx;
        if (CONN8 == 0) begin
            case (nb_idx)
                3'd0:    nb_sel = 3'd1;
                3'd1:    nb_sel = 3'd3;
                3'd2:    nb_sel = 3'd4;
                default: nb_sel = 3'd6;
            endcase
        end
        go_u = 1'b0;
        go_d = 1'b0;
        go_l = 1'b0;
        go_r = 1'b0;
        case (nb_sel)
            3'd0: begin go_u = 1'b1; go_l = 1'b1; end
            3'd1: go_u = 1'b1;
            3'd2: begin go_u = 1'b1; go_r = 1'b1; end
            3'd3: go_l = 1'b1;
            3'd4: go_r = 1'b1;
            3'd5: begin go_d = 1'b1; go_l = 1'b1; end
            3'd6: go_d = 1'b1;
            default: begin go_d = 1'b1; go_r = 1'b1; end
        endcase
        nb_ok = !(go_l && (cur_x == '0)) &&
                !(go_r && (cur_x == XW'(IMG_W - 1))) &&
                !(go_u && (cur_y == '0)) &&
                !(go_d && (cur_y == YW'(IMG_H - 1)));
        nb_x   = cur_x + XW'(go_r) - XW'(go_l);
        nb_y   = cur_y + YW'(go_d) - YW'(go_u);
        nb_px  = {nb_y, nb_x};
        nb_hit = nb_ok && img[nb_px];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control. SCAN handles one pixel per cycle:
    // unqueued background writes 0, foreground seeds a new component,
    // already-queued pixels are skipped since BFS labels them. BFS
    // alternates a pop cycle (write label, latch pixel) with one cycle
    // per neighbour (claim and push if still foreground).
    always_comb begin
        state_nxt = state;
        q_clr     = 1'b0;
        q_push    = 1'b0;
        q_pop     = 1'b0;
        q_din     = scan_idx;
        wr_en     = 1'b0;
        wr_addr   = scan_idx;
        wr_data   = '0;
        new_comp  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    q_clr     = 1'b1;
                end
            end
            LOAD: begin
                if (ld_cnt == LOAD_END) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (img[scan_idx]) begin
                    new_comp  = 1'b1;
                    q_push    = 1'b1;
                    state_nxt = BFS;
                end else begin
                    wr_en = !vis[scan_idx];
                    if (scan_idx == LAST_PIX) begin
                        state_nxt = DONE;
                    end
                end
            end
            BFS: begin
                if (pop_phase) begin
                    if (q_empty) begin
                        state_nxt = (scan_idx == LAST_PIX) ? DONE : SCAN;
                    end else begin
                        q_pop   = 1'b1;
                        wr_en   = 1'b1;
                        wr_addr = q_dout;
                        wr_data = label_cnt;
                    end
                end else if (nb_hit) begin
                    q_push = 1'b1;
                    q_din  = nb_px;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, ROM address, label bookkeeping and the registered SRAM
    // interface. The ROM address stops at the last byte while the load
    // counter runs one extra cycle to catch the final byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_a     <= '0;
            ld_cnt    <= '0;
            scan_idx  <= '0;
            cur_px    <= '0;
            pop_phase <= 1'b1;
            nb_idx    <= '0;
            label_cnt <= '0;
            ovf       <= 1'b0;
            sram_a    <= '0;
            sram_d    <= '0;
            sram_wen  <= 1'b1;
        end else begin
            sram_wen <= !wr_en;
            if (wr_en) begin
                sram_a <= wr_addr;
                sram_d <= wr_data;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rom_a     <= '0;
                        ld_cnt    <= '0;
                        scan_idx  <= '0;
                        label_cnt <= '0;
                        ovf       <= 1'b0;
                        pop_phase <= 1'b1;
                        nb_idx    <= '0;
                    end
                end
                LOAD: begin
                    ld_cnt <= ld_cnt + (RA_W+1)'(1);
                    if (ld_cnt < LAST_BYTE) begin
                        rom_a <= rom_a + RA_W'(1);
                    end
                end
                SCAN: begin
                    if (new_comp) begin
                        if (label_cnt == LBL_MAX) begin
                            ovf <= 1'b1;
                        end else begin
                            label_cnt <= label_cnt + LBL_W'(1);
                        end
                        pop_phase <= 1'b1;
                    end else if (scan_idx != LAST_PIX) begin
                        scan_idx <= scan_idx + PA_W'(1);
                    end
                end
                BFS: begin
                    if (pop_phase) begin
                        if (q_empty) begin
                            if (scan_idx != LAST_PIX) begin
                                scan_idx <= scan_idx + PA_W'(1);
                            end
                        end else begin
                            cur_px    <= q_dout;
                            nb_idx    <= '0;
                            pop_phase <= 1'b0;
                        end
                    end else begin
                        nb_idx <= nb_idx + 3'd1;
                        if (nb_idx == 3'(NNB - 1)) begin
                            pop_phase <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit maps: cleared/reloaded at the start of every run, so they need
    // no reset. A pixel is claimed exactly once, at the moment it is pushed.
    always_ff @(posedge clk) begin
        if (((state == IDLE) || (state == DONE)) && start) begin
            vis <= '0;
        end
        if ((state == LOAD) && (ld_cnt != '0)) begin
            img[{ld_byte, 3'b000} +: 8] <= bit_reverse8(rom_q);
        end
        if (q_push) begin
            img[q_din] <= 1'b0;
            vis[q_din] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cle_param.sv
// Self-checking bench for cle_param. Three instances cover 32x32 8-conn,
// 32x32 4-conn and 64x64 8-conn; they share one ROM image and one SRAM
// model since only one runs at a time. A vector table drives full runs;
// a hand-written sequence covers reset during BFS.
module tb_cle_param;

    typedef struct {
        int dut;
        int pattern;
        int exp_cnt;
        int exp_ovf;
        int a0; int l0;
        int a1; int l1;
        int a2; int l2;
        int a3; int l3;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start_a, start_b, start_c;
    logic [6:0] rom_a_a, rom_a_b;
    logic [8:0] rom_a_c;
    logic [7:0] rom_q_a, rom_q_b, rom_q_c;
    logic [9:0] sram_a_a, sram_a_b;
    logic [11:0] sram_a_c;
    logic [7:0] sram_d_a, sram_d_b, sram_d_c;
    logic       sram_wen_a, sram_wen_b, sram_wen_c;
    logic [7:0] label_cnt_a, label_cnt_b, label_cnt_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic       finish_a, finish_b, finish_c;

    logic [7:0] rom_mem [512];
    bit         pix [4096];
    int         sram_mem [4096];
    int         wcnt [4096];
    int         wbase [4096];
    int         wr_total = 0;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs [6];

    cle_param #(.IMG_W(32), .IMG_H(32), .LBL_W(8), .CONN8(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .rom_a(rom_a_a), .rom_q(rom_q_a),
        .sram_a(sram_a_a), .sram_d(sram_d_a), .sram_wen(sram_wen_a),
        .label_cnt(label_cnt_a), .ovf(ovf_a), .finish(finish_a));

    cle_param #(.IMG_W(32), .IMG_H(32), .LBL_W(8), .CONN8(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .rom_a(rom_a_b), .rom_q(rom_q_b),
        .sram_a(sram_a_b), .sram_d(sram_d_b), .sram_wen(sram_wen_b),
        .label_cnt(label_cnt_b), .ovf(ovf_b), .finish(finish_b));

    cle_param #(.IMG_W(64), .IMG_H(64), .LBL_W(8), .CONN8(1)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .rom_a(rom_a_c), .rom_q(rom_q_c),
        .sram_a(sram_a_c), .sram_d(sram_d_c), .sram_wen(sram_wen_c),
        .label_cnt(label_cnt_c), .ovf(ovf_c), .finish(finish_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data appears one cycle after the address
    always @(posedge clk) begin
        rom_q_a <= rom_mem[int'(rom_a_a)];
        rom_q_b <= rom_mem[int'(rom_a_b)];
        rom_q_c <= rom_mem[int'(rom_a_c)];
    end

    // SRAM model with a per-address write counter
    always @(posedge clk) begin
        if (!sram_wen_a) begin
            sram_mem[int'(sram_a_a)] <= int'(sram_d_a);
            wcnt[int'(sram_a_a)]     <= wcnt[int'(sram_a_a)] + 1;
            wr_total                 <= wr_total + 1;
        end
        if (!sram_wen_b) begin
            sram_mem[int'(sram_a_b)] <= int'(sram_d_b);
            wcnt[int'(sram_a_b)]     <= wcnt[int'(sram_a_b)] + 1;
            wr_total                 <= wr_total + 1;
        end
        if (!sram_wen_c) begin
            sram_mem[int'(sram_a_c)] <= int'(sram_d_c);
            wcnt[int'(sram_a_c)]     <= wcnt[int'(sram_a_c)] + 1;
            wr_total                 <= wr_total + 1;
        end
    end

    function automatic int get_cnt(input int d);
        case (d)
            0:       return int'(label_cnt_a);
            1:       return int'(label_cnt_b);
            default: return int'(label_cnt_c);
        endcase
    endfunction

    function automatic int get_ovf(input int d);
        case (d)
            0:       return int'(ovf_a);
            1:       return int'(ovf_b);
            default: return int'(ovf_c);
        endcase
    endfunction

    function automatic int get_fin(input int d);
        case (d)
            0:       return int'(finish_a);
            1:       return int'(finish_b);
            default: return int'(finish_c);
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        start_a = (d == 0) ? v : 1'b0;
        start_b = (d == 1) ? v : 1'b0;
        start_c = (d == 2) ? v : 1'b0;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Patterns: 0 empty, 1 (0,31)+(1,0), 2 diagonal (5,5)+(6,6),
    // 3 checkerboard (row+col even), 4 all ones
    task automatic build_image(input int pattern, input int w);
        int  idx;
        bit  b;
        for (int i = 0; i < 4096; i++) pix[i] = 1'b0;
        for (int i = 0; i < 512; i++) rom_mem[i] = 8'h00;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                case (pattern)
                    1:       b = (r == 0 && c == 31) || (r == 1 && c == 0);
                    2:       b = (r == 5 && c == 5) || (r == 6 && c == 6);
                    3:       b = ((r + c) % 2) == 0;
                    4:       b = 1'b1;
                    default: b = 1'b0;
                endcase
                idx      = r * w + c;
                pix[idx] = b;
                if (b) rom_mem[idx / 8] = rom_mem[idx / 8] | (8'h80 >> (idx % 8));
            end
        end
    endtask

    // One full run: start, a stray start mid-run (must be ignored),
    // bounded wait for finish, then let the last SRAM write land.
    task automatic apply_stimulus(input int d);
        int cyc;
        for (int i = 0; i < 4096; i++) wbase[i] = wcnt[i];
        @(negedge clk);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        cyc = 0;
        while (get_fin(d) == 0 && cyc < 60000) begin
            set_start(d, cyc == 150);
            @(negedge clk);
            cyc++;
        end
        set_start(d, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_output(input int vi);
        vec_t v;
        int   np;
        int   bad_once;
        int   bad_map;
        int   bad_range;
        v  = vecs[vi];
        np = (v.dut == 2) ? 4096 : 1024;
        check($sformatf("v%0d_finish", vi), get_fin(v.dut), 1);
        check($sformatf("v%0d_label_cnt", vi), get_cnt(v.dut), v.exp_cnt);
        check($sformatf("v%0d_ovf", vi), get_ovf(v.dut), v.exp_ovf);
        check($sformatf("v%0d_pix%0d", vi, v.a0), sram_mem[v.a0], v.l0);
        check($sformatf("v%0d_pix%0d", vi, v.a1), sram_mem[v.a1], v.l1);
        check($sformatf("v%0d_pix%0d", vi, v.a2), sram_mem[v.a2], v.l2);
        check($sformatf("v%0d_pix%0d", vi, v.a3), sram_mem[v.a3], v.l3);
        bad_once  = 0;
        bad_map   = 0;
        bad_range = 0;
        for (int i = 0; i < np; i++) begin
            if (wcnt[i] - wbase[i] != 1) bad_once++;
            if (!pix[i] && sram_mem[i] != 0) bad_map++;
            if (pix[i] && sram_mem[i] == 0) bad_map++;
            if (sram_mem[i] > v.exp_cnt) bad_range++;
        end
        check($sformatf("v%0d_write_once_bad", vi), bad_once, 0);
        check($sformatf("v%0d_fg_bg_bad", vi), bad_map, 0);
        check($sformatf("v%0d_label_range_bad", vi), bad_range, 0);
    endtask

    initial begin
        int found;
        int w0;
        int cyc;

        vecs[0] = '{0, 0,   0, 0,    0, 0, 1023,   0,  517,   0,   31,   0};
        vecs[1] = '{0, 1,   2, 0,   31, 1,   32,   2,    0,   0,   63,   0};
        vecs[2] = '{0, 2,   1, 0,  165, 1,  198,   1,  166,   0,    0,   0};
        vecs[3] = '{1, 2,   2, 0,  165, 1,  198,   2,  166,   0,  197,   0};
        vecs[4] = '{1, 3, 255, 1,    2, 2,  478, 240,  509, 255, 1023, 255};
        vecs[5] = '{2, 4,   1, 0,    0, 1,   63,   1,   64,   1, 4095,   1};

        set_start(0, 1'b0);
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        check("rst_rom_a", int'(rom_a_a), 0);
        check("rst_sram_a", int'(sram_a_a), 0);
        check("rst_sram_d", int'(sram_d_a), 0);
        check("rst_sram_wen", int'(sram_wen_a), 1);
        check("rst_label_cnt", int'(label_cnt_a), 0);
        check("rst_ovf", int'(ovf_a), 0);
        check("rst_finish", int'(finish_a), 0);
        reset = 1'b1;
        @(negedge clk);

        // Reset while a large component is being flooded
        $display("[TB] reset during BFS");
        build_image(4, 32);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        cyc = 0;
        while (label_cnt_a != 8'd1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_bfs_label_seen", int'(label_cnt_a), 1);
        repeat (40) @(negedge clk);
        found = 0;
        cyc   = 0;
        while (found == 0 && cyc < 50) begin
            if (!sram_wen_a) found = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("rst_bfs_write_seen", found, 1);
        reset = 1'b0;
        #1;
        check("rst_bfs_wen", int'(sram_wen_a), 1);
        w0 = wr_total;
        repeat (10) @(negedge clk);
        check("rst_bfs_no_writes", wr_total - w0, 0);
        check("rst_bfs_finish", int'(finish_a), 0);
        check("rst_bfs_label_cnt", int'(label_cnt_a), 0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven full runs
        for (int vi = 0; vi < 6; vi++) begin
            $display("[TB] vector %0d: dut %0d pattern %0d", vi, vecs[vi].dut, vecs[vi].pattern);
            build_image(vecs[vi].pattern, (vecs[vi].dut == 2) ? 64 : 32);
            apply_stimulus(vecs[vi].dut);
            check_output(vi);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cle_param.md
CLE_PARAM -- requirements
Module: cle_param

Interface
REQ-001 Parameter IMG_W, default 32, image width in pixels; power of two, 8..64.
REQ-002 Parameter IMG_H, default 32, image height in pixels; power of two, 8..64.
REQ-003 Parameter LBL_W, default 8, label width in bits.
REQ-004 Parameter CONN8, default 1, neighbourhood mode: 1 = 8-connected, 0 = 4-connected.
REQ-005 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, one-cycle pulse that starts a labeling run; honoured only in IDLE or DONE.
REQ-008 Port rom_a, output, log2(IMG_W*IMG_H/8), ROM byte address.
REQ-009 Port rom_q, input, 8, ROM data valid one cycle after rom_a; bit 7 is the leftmost pixel of the byte; 1 = foreground.
REQ-010 Port sram_a, output, log2(IMG_W*IMG_H), SRAM address = row*IMG_W + col.
REQ-011 Port sram_d, output, LBL_W, label to write.
REQ-012 Port sram_wen, output, 1, active-low write strobe; SRAM captures sram_d at sram_a on the rising edge where sram_wen = 0.
REQ-013 Port label_cnt, output, LBL_W, number of labels assigned in the current or last run.
REQ-014 Port ovf, output, 1, label overflow flag; sticky until the next start.
REQ-015 Port finish, output, 1, high while in DONE.

Function
REQ-016 FSM states: IDLE, LOAD, SCAN, BFS, DONE.
REQ-017 IDLE -> LOAD on start; DONE -> LOAD on start; DONE is otherwise held.
REQ-018 LOAD issues rom_a = 0..IMG_W*IMG_H/8-1 on consecutive cycles and stores each returned byte into an internal bit image; it lasts IMG_W*IMG_H/8+1 cycles, then goes to SCAN.
REQ-019 SCAN visits pixel indices 0..IMG_W*IMG_H-1 in raster order.
REQ-020 In SCAN, a background pixel produces one write of label 0 at its address.
REQ-021 In SCAN, a foreground pixel increments label_cnt, clears its image bit, pushes its index into the queue, and moves to BFS.
REQ-022 BFS pops one index per step and writes the current label to it.
REQ-023 BFS examines the neighbours of each popped index (8 when CONN8=1, N/S/E/W only when CONN8=0); every in-image neighbour whose bit is 1 is cleared and pushed.
REQ-024 Neighbours outside the image are skipped; there is no wrap across row edges or across the top/bottom.
REQ-025 BFS returns to SCAN at the next raster index once the queue is empty; after the last index, SCAN goes to DONE.
REQ-026 Every pixel is written exactly once per run; write order within a component is unspecified.
REQ-027 Labels are 1, 2, 3, ... in order of each component's first raster pixel.
REQ-028 When label_cnt reaches 2^LBL_W-1, further components reuse that label, ovf is set, and label_cnt saturates.
REQ-029 Queue depth is IMG_W*IMG_H; because each pixel is pushed at most once, the queue never overflows.
REQ-030 Simultaneous pop and push in one cycle is legal.
REQ-031 start is ignored in LOAD, SCAN and BFS.
REQ-032 sram_wen is 0 only on cycles with a valid write.

Reset
REQ-033 On reset low: state = IDLE; rom_a, sram_a, sram_d, label_cnt = 0; sram_wen = 1; ovf = 0; finish = 0; queue empty.
REQ-034 A reset asserted mid-run aborts immediately with no further SRAM writes; the image contents are don't-care.
REQ-035 start clears label_cnt, ovf and the queue pointers.

Structure
REQ-036 Package cle_pkg holds the FSM state enum and the address-width derivation functions.
REQ-037 Sub-module cle_queue is a parametrised synchronous FIFO (depth, width, push, pop, empty) instantiated once.

Verification
REQ-038 32x32 all-zero image, start -> 1024 writes of 0, label_cnt = 0, finish = 1, ovf = 0.
REQ-039 Pixels (0,31) and (1,0) set, CONN8=1 -> two labels, 1 and 2 (no row wrap), label_cnt = 2.
REQ-040 Diagonal pixels (5,5) and (6,6): CONN8=1 gives one label, 1; CONN8=0 gives labels 1 and 2.
REQ-041 Checkerboard 32x32, CONN8=0, LBL_W=8 -> label_cnt = 255, ovf = 1, pixels after the 255th component get label 255.
REQ-042 Full-ones 64x64 image -> every address = 1, label_cnt = 1, queue never overflows.
REQ-043 Reset low during BFS -> sram_wen = 1 from the reset edge; a new start produces a correct full run.
